muldiv_sequencer: RTL and testbench

Multi-cycle RV32M sequencer that executes MUL/DIV/DIVU/REM/REMU by borrowing the core's shared ALU one iteration per cycle. It uses the ALU's add (4'b0010) and sub (4'b0110) control codes. It sits beside the execute stage: it takes a request from decode/issue, arbitrates ALU use through a request/grant pair, and returns the result over a valid/ready response port.

---
 rtl/muldiv_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M MUL/DIV/DIVU/REM/REMU engine that
// borrows the core's shared ALU one iteration per cycle via req/grant.
// Optional feature macro: MULDIV_DIV_EN (division/remainder support).
// Without it only MUL is executed; funct3 1xx answers with an error.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_err_o,
    output logic            alu_req_o,
    input  logic            alu_grant_i,
    output logic [3:0]      alu_control_op_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    input  logic [XLEN-1:0] alu_result_i
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        MUL_ITER,
        DIV_ITER,
        FIX,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_first_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_acc;         // MUL accumulator / DIV partial remainder
    logic [XLEN-1:0] r_opa;         // MUL multiplicand / DIV quotient (|dividend| shifts out)
    logic [XLEN-1:0] r_opb;         // MUL multiplier / DIV |divisor|
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_err;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_last;
    logic            w_alu_req;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_first_data;
    logic            w_first_err;
    logic [XLEN-1:0] w_mul_nxt;

    assign w_req_ready = rst_ni && (r_state == IDLE);
    assign w_accept    = req_valid_i && w_req_ready;
    assign w_last      = (r_cnt == 5'd31);
    assign w_mul_nxt   = r_opb[0] ? alu_result_i : r_acc;

`ifdef MULDIV_DIV_EN
    logic            r_is_rem;
    logic            r_s1neg;
    logic            r_s2neg;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_fix;

    // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
    assign w_rem_sh  = {r_acc, r_opa[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_nxt = w_ge ? alu_result_i : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_opa[XLEN-2:0], w_ge};
    assign w_fix     = r_is_rem ? r_s1neg : (r_s1neg ^ r_s2neg);
`endif

    // Decode an incoming request into its first state and any immediate result.
    always_comb begin
        w_first_state = DONE;
        w_first_data  = '0;
        w_first_err   = 1'b0;
        case (req_funct3_i)
            3'b000: w_first_state = MUL_ITER;
`ifdef MULDIV_DIV_EN
            3'b100, 3'b101, 3'b110, 3'b111: begin
                if (req_rs2_i == '0) begin
                    w_first_data = req_funct3_i[1] ? req_rs1_i : '1;
                end else if (!req_funct3_i[0] && (req_rs1_i == INT_MIN) && (req_rs2_i == '1)) begin
                    w_first_data = req_funct3_i[1] ? '0 : INT_MIN;
                end else if (!req_funct3_i[0] && req_rs1_i[XLEN-1]) begin
                    w_first_state = NEG_A;
                end else if (!req_funct3_i[0] && req_rs2_i[XLEN-1]) begin
                    w_first_state = NEG_B;
                end else begin
                    w_first_state = DIV_ITER;
                end
            end
`endif
            default: w_first_err = 1'b1;
        endcase
    end

    // Next-state and ALU drive; every ALU state stalls while grant is low.
    always_comb begin
        w_state_nxt = r_state;
        w_alu_req   = 1'b0;
        w_alu_op    = 4'b0000;
        w_alu_a     = '0;
        w_alu_b     = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = w_first_state;
            end
            MUL_ITER: begin
                w_alu_req = 1'b1;
                w_alu_op  = ALU_ADD;
                w_alu_a   = r_acc;
                w_alu_b   = r_opa;
                if (alu_grant_i && w_last) w_state_nxt = DONE;
            end
`ifdef MULDIV_DIV_EN
            NEG_A: begin
                w_alu_req = 1'b1;
                w_alu_op  = ALU_SUB;
                w_alu_b   = r_opa;
                if (alu_grant_i) w_state_nxt = r_s2neg ? NEG_B : DIV_ITER;
            end
            NEG_B: begin
                w_alu_req = 1'b1;
                w_alu_op  = ALU_SUB;
                w_alu_b   = r_opb;
                if (alu_grant_i) w_state_nxt = DIV_ITER;
            end
            DIV_ITER: begin
                w_alu_req = 1'b1;
                w_alu_op  = ALU_SUB;
                w_alu_a   = w_rem_sh[XLEN-1:0];
                w_alu_b   = r_opb;
                if (alu_grant_i && w_last) w_state_nxt = w_fix ? FIX : DONE;
            end
            FIX: begin
                w_alu_req = 1'b1;
                w_alu_op  = ALU_SUB;
                w_alu_b   = r_is_rem ? r_acc : r_opa;
                if (alu_grant_i) w_state_nxt = DONE;
            end
`endif
            DONE: begin
                if (resp_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control registers: state, iteration counter and the response latch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt       <= '0;
                r_resp_data <= w_first_data;
                r_resp_err  <= w_first_err;
            end else if (alu_grant_i) begin
                case (r_state)
                    MUL_ITER: begin
                        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
                        if (w_last) r_resp_data <= w_mul_nxt;
                    end
`ifdef MULDIV_DIV_EN
                    DIV_ITER: begin
                        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
                        if (w_last && !w_fix) r_resp_data <= r_is_rem ? w_rem_nxt : w_quo_nxt;
                    end
                    FIX: r_resp_data <= alu_result_i;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers: load operands on accept, advance one step per granted cycle.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_acc <= '0;
            r_opa <= req_rs1_i;
            r_opb <= req_rs2_i;
`ifdef MULDIV_DIV_EN
            r_is_rem <= req_funct3_i[1];
            r_s1neg  <= !req_funct3_i[0] && req_rs1_i[XLEN-1];
            r_s2neg  <= !req_funct3_i[0] && req_rs2_i[XLEN-1];
`endif
        end else if (alu_grant_i) begin
            case (r_state)
                MUL_ITER: begin
                    r_acc <= w_mul_nxt;
                    r_opa <= r_opa << 1;
                    r_opb <= r_opb >> 1;
                end
`ifdef MULDIV_DIV_EN
                NEG_A: r_opa <= alu_result_i;
                NEG_B: r_opb <= alu_result_i;
                DIV_ITER: begin
                    r_acc <= w_rem_nxt;
                    r_opa <= w_quo_nxt;
                end
`endif
                default: ;
            endcase
        end
    end

    assign req_ready_o      = w_req_ready;
    assign resp_valid_o     = (r_state == DONE);
    assign resp_data_o      = r_resp_data;
    assign resp_err_o       = r_resp_err;
    assign alu_req_o        = w_alu_req;
    assign alu_control_op_o = w_alu_op;
    assign alu_a_o          = w_alu_a;
    assign alu_b_o          = w_alu_b;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with a behavioural shared ALU.
module tb_muldiv_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        alu_req_o;
    logic        alu_grant_i;
    logic [3:0]  alu_control_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_funct3_i    (req_funct3_i),
        .req_rs1_i       (req_rs1_i),
        .req_rs2_i       (req_rs2_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_data_o     (resp_data_o),
        .resp_err_o      (resp_err_o),
        .alu_req_o       (alu_req_o),
        .alu_grant_i     (alu_grant_i),
        .alu_control_op_o(alu_control_op_o),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .alu_result_i    (alu_result_i)
    );

    // Shared ALU: combinational add/sub of the sequencer's operands.
    assign alu_result_i = (alu_control_op_o == 4'b0110) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency from the accept edge, check result and handshake.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat);
        int   lat;
        logic seen;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_rs1_i    = a;
        req_rs2_i    = b;
        chk({tag, ".ready"}, {31'b0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!resp_valid_o && lat < 200) begin
            seen = seen | alu_req_o;
            @(posedge clk_i); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".data"}, resp_data_o, exp_d);
        chk({tag, ".err"}, {31'b0, resp_err_o}, {31'b0, exp_e});
        chk({tag, ".alureq"}, {31'b0, seen}, {31'b0, (exp_lat > 1)});
        chk({tag, ".busy"}, {31'b0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        chk({tag, ".idle"}, {31'b0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        int   lat;
        logic seen;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_funct3_i = 3'b000;
        req_rs1_i    = '0;
        req_rs2_i    = '0;
        resp_ready_i = 1'b1;
        alu_grant_i  = 1'b1;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst.valid", {31'b0, resp_valid_o}, 32'd0);
        chk("rst.data", resp_data_o, 32'd0);
        chk("rst.err", {31'b0, resp_err_o}, 32'd0);
        chk("rst.alureq", {31'b0, alu_req_o}, 32'd0);
        chk("rst.alua", alu_a_o, 32'd0);
        chk("rst.alub", alu_b_o, 32'd0);
        chk("rst.aluop", {28'b0, alu_control_op_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst.release_ready", {31'b0, req_ready_o}, 32'd1);

        run_op("mul7x6",   3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 33);
        run_op("mulneg",   3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("mulh",     3'b001, 32'd7, 32'd6, 32'd0, 1'b1, 1);
        run_op("mulhu",    3'b011, 32'd7, 32'd6, 32'd0, 1'b1, 1);

`ifdef MULDIV_DIV_EN
        run_op("divu",     3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_op("remu",     3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35);
        run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 35);
        run_op("rem_negb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
        run_op("div_nn",   3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, 1'b0, 35);
        run_op("div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 1'b0, 1);
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
`else
        run_op("div_off",  3'b100, 32'd100, 32'd7, 32'd0, 1'b1, 1);
        run_op("remu_off", 3'b111, 32'd100, 32'd7, 32'd0, 1'b1, 1);
`endif

        // MUL 3x5 with a 5-cycle grant gap and a 3-cycle response backpressure.
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b000;
        req_rs1_i    = 32'd3;
        req_rs2_i    = 32'd5;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 200) begin
            @(negedge clk_i);
            alu_grant_i = !(lat >= 10 && lat < 15);
            if (lat == 12) chk("stall.alureq", {31'b0, alu_req_o}, 32'd1);
            @(posedge clk_i); #1;
            lat++;
        end
        alu_grant_i = 1'b1;
        chk("stall.lat", lat, 38);
        chk("stall.data", resp_data_o, 32'd15);
        repeat (2) begin
            @(posedge clk_i); #1;
            chk("hold.valid", {31'b0, resp_valid_o}, 32'd1);
            chk("hold.data", resp_data_o, 32'd15);
            chk("hold.err", {31'b0, resp_err_o}, 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("hold.release", {31'b0, resp_valid_o}, 32'd0);

        // Reset at iteration 10 of a MUL aborts it with no response.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b000;
        req_rs1_i    = 32'd9;
        req_rs2_i    = 32'd9;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("abort.busy", {31'b0, alu_req_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort.ready_low", {31'b0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("abort.alureq", {31'b0, alu_req_o}, 32'd0);
        chk("abort.valid", {31'b0, resp_valid_o}, 32'd0);
        chk("abort.alua", alu_a_o, 32'd0);
        chk("abort.aluop", {28'b0, alu_control_op_o}, 32'd0);
        chk("abort.data", resp_data_o, 32'd0);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            seen = seen | resp_valid_o;
        end
        chk("abort.noresp", {31'b0, seen}, 32'd0);
        run_op("mul2x2", 3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
